// File: rtl/ch_rr_entry_buf.sv
// Request buffer: lowest-free-slot allocation, round-robin issue from the read pointer.
// Optional occupancy counter port count_o under CH_RR_ENTRY_BUF_CNT_EN.
module ch_rr_entry_buf #(
    parameter int DATA_W  = 32,
    parameter int ENTRIES = 5,
    parameter int PTR_W   = $clog2(ENTRIES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               alloc_valid_i,
    output logic               alloc_ready_o,
    input  logic [DATA_W-1:0]  alloc_data_i,
    output logic               issue_valid_o,
    input  logic               issue_ready_i,
    output logic [DATA_W-1:0]  issue_data_o,
    output logic [PTR_W-1:0]   issue_idx_o,
    output logic [ENTRIES-1:0] entry_valid_o,
    output logic [PTR_W-1:0]   read_ptr_o
`ifdef CH_RR_ENTRY_BUF_CNT_EN
    ,
    output logic [PTR_W:0]     count_o
`endif
);

    logic [ENTRIES-1:0] valid;
    logic [DATA_W-1:0]  data [ENTRIES];
    logic [PTR_W-1:0]   read_ptr;
    logic [PTR_W-1:0]   free_idx;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   ptr_next;
    logic               pick_found;
    logic               alloc_fire;
    logic               issue_fire;

    // Descending scan so the last hit is the lowest free slot.
    always_comb begin
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) free_idx = PTR_W'(i);
        end
    end

    // Walk ENTRIES slots starting at read_ptr, wrapping mod ENTRIES.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] slot;
        pick_idx   = read_ptr;
        pick_found = 1'b0;
        sum        = '0;
        slot       = '0;
        for (int k = 0; k < ENTRIES; k++) begin
            sum = {1'b0, read_ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(ENTRIES)) sum = sum - (PTR_W+1)'(ENTRIES);
            slot = sum[PTR_W-1:0];
            if (!pick_found && valid[slot]) begin
                pick_found = 1'b1;
                pick_idx   = slot;
            end
        end
    end

    assign alloc_ready_o = ~&valid & ~flush_i;
    assign issue_valid_o = |valid & ~flush_i;
    assign alloc_fire    = alloc_valid_i & alloc_ready_o;
    assign issue_fire    = issue_valid_o & issue_ready_i;
    assign issue_idx_o   = pick_idx;
    assign issue_data_o  = data[pick_idx];
    assign entry_valid_o = valid;
    assign read_ptr_o    = read_ptr;
    assign ptr_next      = (pick_idx == PTR_W'(ENTRIES - 1)) ? '0 : pick_idx + PTR_W'(1);

    // The issued slot is valid and the alloc target is free, so they never collide.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            valid    <= '0;
            read_ptr <= '0;
        end else begin
            if (issue_fire) begin
                valid[pick_idx] <= 1'b0;
                read_ptr        <= ptr_next;
            end
            if (alloc_fire) valid[free_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc_fire) data[free_idx] <= alloc_data_i;
    end

`ifdef CH_RR_ENTRY_BUF_CNT_EN
    logic [PTR_W:0] count;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            count <= '0;
        end else if (alloc_fire && !issue_fire) begin
            count <= count + (PTR_W+1)'(1);
        end else if (issue_fire && !alloc_fire) begin
            count <= count - (PTR_W+1)'(1);
        end
    end

    assign count_o = count;
`endif

endmodule

// File: tb/tb_ch_rr_entry_buf.sv
// Randomized scoreboard bench for ch_rr_entry_buf against an array-based reference model.
module tb_ch_rr_entry_buf;
    localparam int N  = 5;
    localparam int PW = 3;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, flush, alloc_valid, alloc_ready, issue_valid, issue_ready;
    logic [DW-1:0] alloc_data, issue_data;
    logic [PW-1:0] issue_idx, read_ptr;
    logic [N-1:0]  entry_valid;
`ifdef CH_RR_ENTRY_BUF_CNT_EN
    logic [PW:0]   count;
`endif

    always #5 clk = ~clk;

    ch_rr_entry_buf #(.DATA_W(DW), .ENTRIES(N)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .alloc_valid_i (alloc_valid),
        .alloc_ready_o (alloc_ready),
        .alloc_data_i  (alloc_data),
        .issue_valid_o (issue_valid),
        .issue_ready_i (issue_ready),
        .issue_data_o  (issue_data),
        .issue_idx_o   (issue_idx),
        .entry_valid_o (entry_valid),
        .read_ptr_o    (read_ptr)
`ifdef CH_RR_ENTRY_BUF_CNT_EN
        ,
        .count_o       (count)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: slot occupancy, slot payloads, round-robin pointer.
    bit            mv [N];
    logic [DW-1:0] md [N];
    int            mptr;
    bit            minit = 1'b0;

    typedef struct {
        int            idx;
        logic [DW-1:0] d;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Valid slot at the smallest forward distance from the pointer; -1 when empty.
    function automatic int mpick();
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (mv[i] && ((i - mptr + N) % N) < bestd) begin
                bestd = (i - mptr + N) % N;
                best  = i;
            end
        end
        return best;
    endfunction

    function automatic int mfree();
        for (int i = 0; i < N; i++) if (!mv[i]) return i;
        return -1;
    endfunction

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(mv[i]);
        return c;
    endfunction

    task automatic step(input bit av, input logic [DW-1:0] ad, input bit rdy, input bit fl, input bit rs);
        int            pick, fr, eidx;
        bit            ear, eiv;
        logic [N-1:0]  ev;
        exp_t          e;
        @(negedge clk);
        alloc_valid = av;
        alloc_data  = ad;
        issue_ready = rdy;
        flush       = fl;
        rst         = rs;
        #1;
        if (minit) begin
            pick = mpick();
            fr   = mfree();
            ear  = (fr >= 0) && !fl;
            eiv  = (pick >= 0) && !fl;
            eidx = (pick >= 0) ? pick : mptr;
            for (int i = 0; i < N; i++) ev[i] = mv[i];
            chk("alloc_ready", alloc_ready, ear);
            chk("issue_valid", issue_valid, eiv);
            chk("entry_valid", entry_valid, ev);
            chk("read_ptr", read_ptr, mptr);
            chk("issue_idx", issue_idx, eidx);
`ifdef CH_RR_ENTRY_BUF_CNT_EN
            chk("count", count, mcount());
`endif
            if (eiv && rdy) begin
                e.idx = pick;
                e.d   = md[pick];
                q.push_back(e);
            end
            if (!rs && !fl) begin
                if (eiv && rdy) begin
                    mv[pick] = 1'b0;
                    mptr     = (pick + 1) % N;
                end
                if (ear && av) begin
                    mv[fr] = 1'b1;
                    md[fr] = ad;
                end
            end
        end
        if (rs || (minit && fl)) begin
            for (int i = 0; i < N; i++) mv[i] = 1'b0;
            mptr  = 0;
            minit = 1'b1;
        end
    endtask

    // Monitor: every accepted issue must match the oldest expected issue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (issue_valid === 1'b1 && issue_ready === 1'b1) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL issue_unexpected: got idx %0d expected no issue", issue_idx);
                end else begin
                    e = q.pop_front();
                    chk("issued_idx", issue_idx, e.idx);
                    chk("issued_data", issue_data, e.d);
                end
            end
        end
    end

    initial begin
        alloc_valid = 1'b0;
        alloc_data  = '0;
        issue_ready = 1'b0;
        flush       = 1'b0;
        rst         = 1'b1;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);

        // Back-to-back allocs until full, then drain in round-robin order.
        for (int i = 0; i < N; i++) step(1, 32'hA0 + i, 0, 0, 0);
        step(1, 32'hEE, 0, 0, 0);
        for (int i = 0; i < N; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // Full with a simultaneous issue: the freed slot is refilled only next cycle.
        for (int i = 0; i < N; i++) step(1, 32'hB0 + i, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 32'hC0, 0, 0, 0);
        step(1, 32'hC1, 0, 0, 0);
        step(1, 32'hC2, 1, 0, 0);
        step(1, 32'hC3, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Flush outranks alloc and issue.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 32'hD0 + i, 0, 0, 0);
        step(1, 32'hDD, 1, 1, 0);
        step(0, 0, 0, 0, 0);

        // Counter sequence: alloc x3, alloc+issue, issue, then reset.
        for (int i = 0; i < 3; i++) step(1, 32'hE0 + i, 0, 0, 0);
        step(1, 32'hE3, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        for (int c = 0; c < 2000; c++) begin
            step(($urandom % 10) < 6, $urandom, $urandom % 2,
                 ($urandom % 40) == 0, ($urandom % 150) == 0);
        end

        step(0, 0, 0, 0, 0);
        @(negedge clk);
        #3;
        chk("scoreboard_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
